ex_issue_ctl: RTL and testbench
===============================

# ex_issue_ctl

Issue and sequencing controller for the execute stage of the x86-64 pipeline. Between decode/register-read and the ALU, it decides each cycle whether the next instruction may enter execute. It tracks the 16-entry register scoreboard, stalls on RAW/WAW hazards and on an active store in the memory stage, and holds execute busy for multi-cycle operations (IMUL, shifts). It produces the execute-start and writeback-valid strobes used by the execute and writeback stages.

## Interface
- NREG, 16, architectural GPRs tracked by the scoreboard
- MUL_LAT, 3, execute cycles occupied by IMUL (opcode 0xF7), legal range 1..15
- clk  in  1  pipeline clock (bus.clk)
- reset  in  1  reset; one clock, reset is synchronous and active-high
- id_valid  in  1  decoded instruction present
- id_opcode  in  8  primary opcode
- id_src_a / id_src_b  in  4 each  source register indices
- id_src_a_used / id_src_b_used  in  1 each  source is read
- id_dst  in  4  primary destination (rm)
- id_dst_used  in  1  primary destination is written
- id_dst2  in  4  secondary destination (reg field, or RDX for IMUL)
- id_dst2_used  in  1  secondary destination is written (dep==2 case)
- id_shift_cnt  in  6  shift count for opcodes 0xC1/0xD1/0xD3
- mem_store_active  in  1  store occupies the memory stage
- flush  in  1  taken jump; squash the instruction offered this cycle
- wb_valid  in  1  writeback retiring this cycle
- wb_dst / wb_dst2  in  4 each  registers retired
- wb_dst2_valid  in  1  wb_dst2 is meaningful
- id_ready  out  1  combinational; instruction accepted at this edge
- ex_start  out  1  one-cycle pulse; execute latches the operands (can_execute)
- ex_busy  out  1  execute is occupied
- ex_done  out  1  one-cycle pulse; result valid for EX/WB register (can_writeback)
- score_board  out  NREG  bit r = 1 while register r has a pending write

## Operation
- States: IDLE, BUSY. Reset → IDLE; all outputs 0, score_board all 0, counter 0.
- Hazard for a used field: score_board[idx] == 1 and not cleared by this cycle's writeback. Checked on src_a, src_b, dst, dst2, so RAW and WAW are both covered.
- id_ready = id_valid & !flush & !mem_store_active & no hazard & (IDLE, or BUSY with counter == 1).
- Accept: set score_board[id_dst] if id_dst_used and score_board[id_dst2] if id_dst2_used; load latency L into the counter; go to BUSY.
- L: MUL_LAT for 0xF7. max(1, id_shift_cnt) for 0xC1/0xD1/0xD3. 1 for all other opcodes.
- Conditional jumps 0x74/0x7D: L = 1, no destination bits set. ex_done is still suppressed for them, because no writeback occurs.
- BUSY: the counter decrements each cycle. At counter == 1, ex_done pulses and the state returns to IDLE unless a new accept occurs in the same cycle.
- Writeback clear: on wb_valid, clear score_board[wb_dst], and also score_board[wb_dst2] if wb_dst2_valid.
- Set/clear on the same bit in the same cycle: set wins.
- flush forces id_ready = 0 for that cycle only. An in-flight operation completes normally.
- Reset mid-operation: the counter is abandoned, no ex_done is emitted, and the scoreboard clears.

## Timing
- Accept at edge T: ex_start = 1 in cycle T+1 and score bits are visible from T+1. ex_busy is high T+1..T+L, and ex_done is high in T+L.
- L = 1 sustains one accept per cycle.
- A dependent instruction can be accepted in the same cycle as the producer's wb_valid, through the writeback bypass.
- mem_store_active blocks accepts only. It does not stall the counter.
- Counter width: 6 bits. A shift count of 63 gives L = 63 with no wrap.

## Test plan
- Reset → id_ready 0, ex_start/ex_busy/ex_done 0, score_board 0x0000.
- Four independent ADDs (0x01, dst 1..4), id_valid held high → accepted on consecutive cycles; ex_done every cycle from T+1; score_board bits 1..4 set.
- MOV imm to r3, then OR using r3 as src_a → second instruction stalls until the cycle wb_valid with wb_dst=3, then is accepted.
- IMUL (0xF7, dst 0, dst2 2) with MUL_LAT=3 → ex_busy high 3 cycles; ex_done only in the 3rd; bits 0 and 2 set.
- SHL 0xC1 with shift_cnt 0 → L=1; with cnt 5 → ex_busy 5 cycles; a follower is accepted in cycle 5.
- flush with id_valid → no accept. mem_store_active high → no accept. reset during an IMUL → no ex_done, scoreboard cleared the next cycle.

Source files
------------

// File: rtl/ex_issue_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : ex_issue_ctl
//  Brief    : Execute-stage issue controller: register scoreboard, RAW/WAW
//             and store stalls, multi-cycle occupancy, start/done strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_issue_ctl #(
    parameter int NREG    = 16,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [7:0]      id_opcode,
    input  logic [3:0]      id_src_a,
    input  logic [3:0]      id_src_b,
    input  logic            id_src_a_used,
    input  logic            id_src_b_used,
    input  logic [3:0]      id_dst,
    input  logic            id_dst_used,
    input  logic [3:0]      id_dst2,
    input  logic            id_dst2_used,
    input  logic [5:0]      id_shift_cnt,
    input  logic            mem_store_active,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [3:0]      wb_dst,
    input  logic [3:0]      wb_dst2,
    input  logic            wb_dst2_valid,
    output logic            id_ready,
    output logic            ex_start,
    output logic            ex_busy,
    output logic            ex_done,
    output logic [NREG-1:0] score_board
);

    localparam logic [7:0] c_OP_IMUL   = 8'hF7;
    localparam logic [7:0] c_OP_SHL_IB = 8'hC1;
    localparam logic [7:0] c_OP_SHL_1  = 8'hD1;
    localparam logic [7:0] c_OP_SHL_CL = 8'hD3;
    localparam logic [7:0] c_OP_JZ     = 8'h74;
    localparam logic [7:0] c_OP_JGE    = 8'h7D;
    localparam logic [5:0] c_MUL_LAT   = 6'(MUL_LAT);
    localparam logic [5:0] c_CNT_LAST  = 6'd1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [5:0]      r_cnt;
    logic            r_ex_start;
    logic            r_no_wb;
    logic [NREG-1:0] r_sb;

    logic [5:0]      w_lat;
    logic            w_is_jump;
    logic            w_is_shift;
    logic            w_slot_free;
    logic            w_hazard;
    logic            w_accept;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_pending;

    function automatic logic [NREG-1:0] f_onehot(input logic [3:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_is_jump  = (id_opcode == c_OP_JZ) || (id_opcode == c_OP_JGE);
    assign w_is_shift = (id_opcode == c_OP_SHL_IB) || (id_opcode == c_OP_SHL_1) ||
                        (id_opcode == c_OP_SHL_CL);

    always_comb begin
        w_lat = 6'd1;
        if (id_opcode == c_OP_IMUL) begin
            w_lat = c_MUL_LAT;
        end else if (w_is_shift) begin
            w_lat = (id_shift_cnt == 6'd0) ? 6'd1 : id_shift_cnt;
        end
    end

    // Writeback bypass: a bit retiring this cycle no longer counts as pending.
    always_comb begin
        w_clr = '0;
        if (wb_valid) begin
            w_clr = f_onehot(wb_dst);
            if (wb_dst2_valid) begin
                w_clr = w_clr | f_onehot(wb_dst2);
            end
        end
    end

    assign w_pending = r_sb & ~w_clr;

    assign w_hazard = (id_src_a_used & w_pending[id_src_a]) |
                      (id_src_b_used & w_pending[id_src_b]) |
                      (id_dst_used   & w_pending[id_dst])   |
                      (id_dst2_used  & w_pending[id_dst2]);

    assign w_slot_free = (r_state == S_IDLE) || (r_cnt == c_CNT_LAST);

    assign w_accept = id_valid & ~flush & ~mem_store_active & ~w_hazard &
                      w_slot_free & ~reset;

    // Jumps write no register, so they never reserve scoreboard bits.
    always_comb begin
        w_set = '0;
        if (w_accept && !w_is_jump) begin
            if (id_dst_used) begin
                w_set = w_set | f_onehot(id_dst);
            end
            if (id_dst2_used) begin
                w_set = w_set | f_onehot(id_dst2);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if ((r_cnt == c_CNT_LAST) && !w_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ex_busy = (r_state == S_BUSY);
        ex_done = (r_state == S_BUSY) && (r_cnt == c_CNT_LAST) && !r_no_wb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 6'd0;
            r_ex_start <= 1'b0;
            r_no_wb    <= 1'b0;
            r_sb       <= '0;
        end else begin
            r_ex_start <= w_accept;
            r_sb       <= (r_sb & ~w_clr) | w_set;
            if (w_accept) begin
                r_cnt   <= w_lat;
                r_no_wb <= w_is_jump;
            end else if ((r_state == S_BUSY) && (r_cnt != 6'd0)) begin
                r_cnt <= r_cnt - 6'd1;
            end
        end
    end

    assign id_ready    = w_accept;
    assign ex_start    = r_ex_start;
    assign score_board = r_sb;

endmodule
`default_nettype wire

// File: tb/tb_ex_issue_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_issue_ctl
//  Brief    : Self-checking bench for ex_issue_ctl with an ex_done scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_issue_ctl;

    localparam int NREG    = 16;
    localparam int MUL_LAT = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [7:0]      id_opcode;
    logic [3:0]      id_src_a, id_src_b;
    logic            id_src_a_used, id_src_b_used;
    logic [3:0]      id_dst, id_dst2;
    logic            id_dst_used, id_dst2_used;
    logic [5:0]      id_shift_cnt;
    logic            mem_store_active, flush;
    logic            wb_valid;
    logic [3:0]      wb_dst, wb_dst2;
    logic            wb_dst2_valid;
    logic            id_ready, ex_start, ex_busy, ex_done;
    logic [NREG-1:0] score_board;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;
    int unsigned exp_done_q[$];
    bit mon_en = 1'b1;

    ex_issue_ctl #(.NREG(NREG), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_src_a_used(id_src_a_used), .id_src_b_used(id_src_b_used),
        .id_dst(id_dst), .id_dst_used(id_dst_used),
        .id_dst2(id_dst2), .id_dst2_used(id_dst2_used),
        .id_shift_cnt(id_shift_cnt),
        .mem_store_active(mem_store_active), .flush(flush),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_dst2(wb_dst2),
        .wb_dst2_valid(wb_dst2_valid),
        .id_ready(id_ready), .ex_start(ex_start), .ex_busy(ex_busy),
        .ex_done(ex_done), .score_board(score_board)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ex_done must appear exactly in the cycles recorded in the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (exp_done_q.size() > 0 && exp_done_q[0] <= cyc) begin
                void'(exp_done_q.pop_front());
                if (ex_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ex_done_pulse cyc=%0d got %b want 1", cyc, ex_done);
                end
            end else if (ex_done !== 1'b0) begin
                n_fail++;
                $display("FAIL ex_done_spurious cyc=%0d got %b want 0", cyc, ex_done);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_opcode = 8'h00; id_src_a = 0; id_src_b = 0;
        id_src_a_used = 0; id_src_b_used = 0; id_dst = 0; id_dst_used = 0;
        id_dst2 = 0; id_dst2_used = 0; id_shift_cnt = 0;
        mem_store_active = 0; flush = 0;
        wb_valid = 0; wb_dst = 0; wb_dst2 = 0; wb_dst2_valid = 0;
    endtask

    task automatic set_instr(input logic [7:0] op, input logic [3:0] sa, input logic sau,
                             input logic [3:0] d, input logic du, input logic [3:0] d2,
                             input logic d2u, input logic [5:0] sc);
        id_valid = 1; id_opcode = op; id_src_a = sa; id_src_a_used = sau;
        id_src_b = 4'd15; id_src_b_used = 0;
        id_dst = d; id_dst_used = du; id_dst2 = d2; id_dst2_used = d2u; id_shift_cnt = sc;
    endtask

    task automatic retire(input logic [3:0] a, input logic [3:0] b, input logic bv);
        wb_valid = 1; wb_dst = a; wb_dst2 = b; wb_dst2_valid = bv;
        tick();
        wb_valid = 0; wb_dst2_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        n_tests++;
        if ({id_ready, ex_start, ex_busy, ex_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0000", {id_ready, ex_start, ex_busy, ex_done});
        end
        n_tests++;
        if (score_board !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_scoreboard got %h want 0000", score_board);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            set_instr(8'h01, 4'd8, 1'b1, 4'(i), 1'b1, 4'd0, 1'b0, 6'd0);
            #1;
            n_tests++;
            if (id_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready i=%0d got %b want 1", i, id_ready);
            end
            exp_done_q.push_back(cyc + 1);
            tick();
            n_tests++;
            if ({ex_start, ex_busy} !== 2'b11) begin
                n_fail++;
                $display("FAIL b2b_start_busy i=%0d got %b want 11", i, {ex_start, ex_busy});
            end
        end
        idle_inputs();
        n_tests++;
        if (score_board !== 16'h001E) begin
            n_fail++;
            $display("FAIL b2b_scoreboard got %h want 001e", score_board);
        end
        tick();
        n_tests++;
        if ({ex_start, ex_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_idle got %b want 00", {ex_start, ex_busy});
        end
        retire(4'd1, 4'd2, 1'b1);
        retire(4'd3, 4'd4, 1'b1);
        n_tests++;
        if (score_board !== 16'h0000) begin
            n_fail++;
            $display("FAIL b2b_clear got %h want 0000", score_board);
        end
    endtask

    task automatic test_raw();
        set_instr(8'hB8, 4'd0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 6'd0);
        exp_done_q.push_back(cyc + 1);
        tick();
        n_tests++;
        if (score_board !== 16'h0008) begin
            n_fail++;
            $display("FAIL raw_producer_sb got %h want 0008", score_board);
        end
        set_instr(8'h09, 4'd3, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 6'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (id_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL raw_stall k=%0d got %b want 0", k, id_ready);
            end
            tick();
        end
        wb_valid = 1; wb_dst = 4'd3;
        #1;
        n_tests++;
        if (id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_bypass_ready got %b want 1", id_ready);
        end
        exp_done_q.push_back(cyc + 1);
        tick();
        idle_inputs();
        n_tests++;
        if (score_board !== 16'h0020) begin
            n_fail++;
            $display("FAIL raw_sb_after got %h want 0020", score_board);
        end
        retire(4'd5, 4'd0, 1'b0);
    endtask

    task automatic test_imul();
        set_instr(8'hF7, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 6'd0);
        mem_store_active = 0;
        #1;
        n_tests++;
        if (id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL imul_ready got %b want 1", id_ready);
        end
        exp_done_q.push_back(cyc + MUL_LAT);
        tick();
        n_tests++;
        if ({ex_start, score_board} !== {1'b1, 16'h0005}) begin
            n_fail++;
            $display("FAIL imul_start_sb got %b/%h want 1/0005", ex_start, score_board);
        end
        set_instr(8'h01, 4'd9, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 6'd0);
        for (int k = 1; k <= MUL_LAT; k++) begin
            #1;
            n_tests++;
            if ({ex_busy, id_ready} !== {1'b1, (k == MUL_LAT)}) begin
                n_fail++;
                $display("FAIL imul_busy_ready k=%0d got %b want %b", k, {ex_busy, id_ready},
                         {1'b1, (k == MUL_LAT)});
            end
            if (k == MUL_LAT) exp_done_q.push_back(cyc + 1);
            tick();
        end
        idle_inputs();
        n_tests++;
        if ({ex_start, ex_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL imul_follower_start got %b want 11", {ex_start, ex_busy});
        end
        tick();
        n_tests++;
        if (ex_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL imul_end_busy got %b want 0", ex_busy);
        end
        retire(4'd0, 4'd2, 1'b1);
        retire(4'd7, 4'd0, 1'b0);
    endtask

    task automatic test_shift();
        set_instr(8'hC1, 4'd0, 1'b0, 4'd10, 1'b1, 4'd0, 1'b0, 6'd0);
        exp_done_q.push_back(cyc + 1);
        tick();
        idle_inputs();
        tick();
        n_tests++;
        if (ex_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL shl_cnt0_busy got %b want 0", ex_busy);
        end
        set_instr(8'hC1, 4'd0, 1'b0, 4'd11, 1'b1, 4'd0, 1'b0, 6'd5);
        exp_done_q.push_back(cyc + 5);
        tick();
        set_instr(8'h01, 4'd8, 1'b1, 4'd12, 1'b1, 4'd0, 1'b0, 6'd0);
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_tests++;
            if ({ex_busy, id_ready} !== {1'b1, (k == 5)}) begin
                n_fail++;
                $display("FAIL shl_cnt5 k=%0d got %b want %b", k, {ex_busy, id_ready}, {1'b1, (k == 5)});
            end
            if (k == 5) exp_done_q.push_back(cyc + 1);
            tick();
        end
        idle_inputs();
        tick();
        set_instr(8'hD3, 4'd0, 1'b0, 4'd14, 1'b1, 4'd0, 1'b0, 6'd63);
        exp_done_q.push_back(cyc + 63);
        tick();
        idle_inputs();
        for (int k = 1; k < 63; k++) tick();
        n_tests++;
        if (ex_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL shl_cnt63_busy_last got %b want 1", ex_busy);
        end
        tick();
        n_tests++;
        if (ex_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL shl_cnt63_end got %b want 0", ex_busy);
        end
        retire(4'd10, 4'd11, 1'b1);
        retire(4'd12, 4'd14, 1'b1);
        n_tests++;
        if (score_board !== 16'h0000) begin
            n_fail++;
            $display("FAIL shl_clear got %h want 0000", score_board);
        end
    endtask

    task automatic test_flush_store_jump();
        set_instr(8'h01, 4'd0, 1'b0, 4'd13, 1'b1, 4'd0, 1'b0, 6'd0);
        flush = 1;
        #1;
        n_tests++;
        if (id_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready got %b want 0", id_ready);
        end
        tick();
        flush = 0; mem_store_active = 1;
        #1;
        n_tests++;
        if ({id_ready, ex_start, score_board} !== {2'b00, 16'h0000}) begin
            n_fail++;
            $display("FAIL store_block got %b/%b/%h want 0/0/0000", id_ready, ex_start, score_board);
        end
        tick();
        mem_store_active = 0;
        #1;
        n_tests++;
        if (id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL unblock_ready got %b want 1", id_ready);
        end
        exp_done_q.push_back(cyc + 1);
        tick();
        set_instr(8'h74, 4'd13, 1'b0, 4'd6, 1'b0, 4'd0, 1'b0, 6'd0);
        #1;
        n_tests++;
        if ({ex_start, id_ready, score_board} !== {2'b11, 16'h2000}) begin
            n_fail++;
            $display("FAIL jump_issue got %b%b/%h want 11/2000", ex_start, id_ready, score_board);
        end
        tick();
        idle_inputs();
        n_tests++;
        if ({ex_start, ex_busy, score_board} !== {2'b11, 16'h2000}) begin
            n_fail++;
            $display("FAIL jump_nodest got %b/%h want 11/2000", {ex_start, ex_busy}, score_board);
        end
        retire(4'd13, 4'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_instr(8'hF7, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 6'd0);
        tick();
        idle_inputs();
        n_tests++;
        if ({ex_busy, score_board} !== {1'b1, 16'h0005}) begin
            n_fail++;
            $display("FAIL rstmid_pre got %b/%h want 1/0005", ex_busy, score_board);
        end
        reset = 1;
        tick();
        n_tests++;
        if ({id_ready, ex_start, ex_busy, score_board} !== {3'b000, 16'h0000}) begin
            n_fail++;
            $display("FAIL rstmid_clear got %b/%h want 000/0000",
                     {id_ready, ex_start, ex_busy}, score_board);
        end
        reset = 0;
        tick(); tick(); tick();
        n_tests++;
        if (ex_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after got %b want 0", ex_busy);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_raw();
        test_imul();
        test_shift();
        test_flush_store_jump();
        test_reset_mid();
        tick();
        mon_en = 0;
        n_tests++;
        if (exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_queue_drain got %0d pending want 0", exp_done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
